// File: rtl/fcl_pkg.sv
// Shared types and default sizing for the fully-connected layer blocks.
package fcl_pkg;

    localparam int FC_DATA_WIDTH  = 8;
    localparam int FC_NUM_NEURONS = 10;

    typedef enum logic {
        SER_IDLE,
        SER_STREAM
    } ser_state_t;

endpackage

// File: rtl/fcl_out_serializer_if.sv
// Load/vector input plus valid/ready element stream of the FC output serializer.
interface fcl_out_serializer_if
    import fcl_pkg::*;
#(
    parameter int DATA_WIDTH  = FC_DATA_WIDTH,
    parameter int NUM_NEURONS = FC_NUM_NEURONS
);
    localparam int IDX_WIDTH = $clog2(NUM_NEURONS);

    logic                              ser_load_i;
    logic [NUM_NEURONS*DATA_WIDTH-1:0] ser_data_i;
    logic                              ser_busy_o;
    logic                              ser_valid_o;
    logic                              ser_ready_i;
    logic [DATA_WIDTH-1:0]             ser_data_o;
    logic [IDX_WIDTH-1:0]              ser_idx_o;
    logic                              ser_last_o;
    logic                              ser_drop_o;

    // The serializer itself.
    modport master (
        input  ser_load_i, ser_data_i, ser_ready_i,
        output ser_busy_o, ser_valid_o, ser_data_o, ser_idx_o, ser_last_o, ser_drop_o
    );

    // The FC layer loading vectors and the next stage consuming elements.
    modport slave (
        output ser_load_i, ser_data_i, ser_ready_i,
        input  ser_busy_o, ser_valid_o, ser_data_o, ser_idx_o, ser_last_o, ser_drop_o
    );
endinterface

// File: rtl/fcl_out_serializer.sv
// Captures a whole FC output vector on a load pulse and streams it out one
// element per cycle over valid/ready, with chained loads on the final transfer.
module fcl_out_serializer
    import fcl_pkg::*;
#(
    parameter int DATA_WIDTH  = FC_DATA_WIDTH,
    parameter int NUM_NEURONS = FC_NUM_NEURONS
) (
    input  logic                  ser_clk,
    input  logic                  ser_rst,
    fcl_out_serializer_if.master  ser_if
);
    localparam int                 IDX_WIDTH = $clog2(NUM_NEURONS);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

    ser_state_t           state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] buffer_q [NUM_NEURONS];
    logic                 drop_q, drop_d;
    logic                 capture;
    logic                 transfer;
    logic                 at_last;

    assign at_last  = (idx_q == LAST_IDX);
    assign transfer = (state_q == SER_STREAM) && ser_if.ser_ready_i;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        drop_d  = 1'b0;
        unique case (state_q)
            SER_IDLE: begin
                if (ser_if.ser_load_i) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = SER_STREAM;
                end
            end
            SER_STREAM: begin
                if (transfer && at_last) begin
                    idx_d = '0;
                    if (ser_if.ser_load_i) begin
                        capture = 1'b1;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else begin
                    if (transfer) begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                    // A load that cannot chain onto the final transfer is dropped.
                    drop_d = ser_if.ser_load_i;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge ser_clk or posedge ser_rst) begin
        if (ser_rst) begin
            state_q <= SER_IDLE;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the capture buffer is reset deliberately; a stale vector must
    // never be visible on ser_data_o after reset.
    always_ff @(posedge ser_clk or posedge ser_rst) begin
        if (ser_rst) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                buffer_q[k] <= '0;
            end
        end else if (capture) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                buffer_q[k] <= ser_if.ser_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Outputs decode flop contents only; nothing here sees ready or load.
    always_comb begin
        ser_if.ser_valid_o = (state_q == SER_STREAM);
        ser_if.ser_busy_o  = (state_q == SER_STREAM);
        ser_if.ser_idx_o   = idx_q;
        ser_if.ser_last_o  = (state_q == SER_STREAM) && at_last;
        ser_if.ser_drop_o  = drop_q;
        ser_if.ser_data_o  = '0;
        if (state_q == SER_STREAM) begin
            ser_if.ser_data_o = buffer_q[idx_q];
        end
    end

endmodule

// File: tb/tb_fcl_out_serializer.sv
// Directed bench for fcl_out_serializer: streaming, backpressure, dropped and
// chained loads, mid-stream reset and input-vector isolation.
module tb_fcl_out_serializer;
    localparam int DW = 8;
    localparam int NN = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [NN*DW-1:0] vec_a;
    logic [NN*DW-1:0] vec_aa;
    logic [NN*DW-1:0] vec_55;
    logic [NN*DW-1:0] vec_ff;

    always #5 clk = ~clk;

    fcl_out_serializer_if #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) ser_if ();

    fcl_out_serializer #(.DATA_WIDTH(DW), .NUM_NEURONS(NN)) dut (
        .ser_clk (clk),
        .ser_rst (rst),
        .ser_if  (ser_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_elem(input string tag, input int k, input logic [7:0] exp_data);
        check({tag, " valid"}, 32'(ser_if.ser_valid_o), 32'd1);
        check({tag, " busy"},  32'(ser_if.ser_busy_o),  32'd1);
        check({tag, " idx"},   32'(ser_if.ser_idx_o),   32'(k));
        check({tag, " data"},  32'(ser_if.ser_data_o),  32'(exp_data));
        check({tag, " last"},  32'(ser_if.ser_last_o),  32'(k == NN - 1));
    endtask

    task automatic check_idle(input string tag);
        check({tag, " valid"}, 32'(ser_if.ser_valid_o), 32'd0);
        check({tag, " busy"},  32'(ser_if.ser_busy_o),  32'd0);
    endtask

    task automatic load_vec(input logic [NN*DW-1:0] v);
        ser_if.ser_data_i = v;
        ser_if.ser_load_i = 1'b1;
        step();
        ser_if.ser_load_i = 1'b0;
    endtask

    initial begin
        int  k;
        int  cyc;
        logic rdy;

        for (int i = 0; i < NN; i++) begin
            vec_a[i*DW +: DW] = 8'(i + 1);
        end
        vec_aa = {NN{8'hAA}};
        vec_55 = {NN{8'h55}};
        vec_ff = {NN{8'hFF}};

        ser_if.ser_load_i  = 1'b0;
        ser_if.ser_data_i  = '0;
        ser_if.ser_ready_i = 1'b0;

        // Reset state
        #2;
        check("rst valid", 32'(ser_if.ser_valid_o), 32'd0);
        check("rst busy",  32'(ser_if.ser_busy_o),  32'd0);
        check("rst data",  32'(ser_if.ser_data_o),  32'd0);
        check("rst idx",   32'(ser_if.ser_idx_o),   32'd0);
        check("rst last",  32'(ser_if.ser_last_o),  32'd0);
        check("rst drop",  32'(ser_if.ser_drop_o),  32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check_idle("post-rst");

        // 1: full-rate stream
        ser_if.ser_ready_i = 1'b1;
        load_vec(vec_a);
        for (int i = 0; i < NN; i++) begin
            check_elem("s1", i, 8'(i + 1));
            check("s1 drop", 32'(ser_if.ser_drop_o), 32'd0);
            step();
        end
        check_idle("s1 end");
        check("s1 end idx", 32'(ser_if.ser_idx_o), 32'd0);

        // 2: ready pattern 1,0,0 repeating
        ser_if.ser_ready_i = 1'b0;
        load_vec(vec_a);
        k   = 0;
        cyc = 0;
        while (k < NN && cyc < 40) begin
            check_elem("s2", k, 8'(k + 1));
            rdy = (cyc % 3 == 0);
            ser_if.ser_ready_i = rdy;
            step();
            if (rdy) k++;
            cyc++;
        end
        check("s2 count", 32'(k), 32'(NN));
        check_idle("s2 end");

        // 3: ignored load at idx=4
        ser_if.ser_ready_i = 1'b1;
        load_vec(vec_a);
        for (int i = 0; i < NN; i++) begin
            check_elem("s3", i, 8'(i + 1));
            if (i == 4) begin
                ser_if.ser_data_i = vec_aa;
                ser_if.ser_load_i = 1'b1;
            end
            step();
            ser_if.ser_load_i = 1'b0;
            check("s3 drop", 32'(ser_if.ser_drop_o), 32'(i == 4));
        end
        check_idle("s3 end");

        // 4: chained load on the idx=9 transfer
        load_vec(vec_a);
        for (int i = 0; i < NN; i++) begin
            check_elem("s4a", i, 8'(i + 1));
            if (i == NN - 1) begin
                ser_if.ser_data_i = vec_55;
                ser_if.ser_load_i = 1'b1;
            end
            step();
            ser_if.ser_load_i = 1'b0;
        end
        check("s4 drop", 32'(ser_if.ser_drop_o), 32'd0);
        for (int i = 0; i < NN; i++) begin
            check_elem("s4b", i, 8'h55);
            step();
        end
        check_idle("s4 end");

        // 5: async reset during a stall at idx=6
        load_vec(vec_a);
        for (int i = 0; i < 6; i++) step();
        ser_if.ser_ready_i = 1'b0;
        check_elem("s5 pre", 6, 8'd7);
        step();
        check_elem("s5 stall", 6, 8'd7);
        #3;
        rst = 1'b1;
        #1;
        check("s5 rst valid", 32'(ser_if.ser_valid_o), 32'd0);
        check("s5 rst busy",  32'(ser_if.ser_busy_o),  32'd0);
        check("s5 rst data",  32'(ser_if.ser_data_o),  32'd0);
        check("s5 rst idx",   32'(ser_if.ser_idx_o),   32'd0);
        check("s5 rst last",  32'(ser_if.ser_last_o),  32'd0);
        check("s5 rst drop",  32'(ser_if.ser_drop_o),  32'd0);
        step();
        rst = 1'b0;
        ser_if.ser_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("s5 post");
        end

        // 6: input vector changes right after capture
        load_vec(vec_a);
        ser_if.ser_data_i = vec_ff;
        for (int i = 0; i < NN; i++) begin
            check_elem("s6", i, 8'(i + 1));
            step();
        end
        check_idle("s6 end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
